lane_tx_serializer: RTL and testbench
=====================================

LANE_TX_SERIALIZER -- requirements
Module: lane_tx_serializer

Interface
REQ-001 Parameter SYNC_BC, default 4: number of idle bytes the block SHALL send after reset before any payload byte.
REQ-002 Parameter IDLE_K, default 8'hBC: idle/comma byte the block SHALL send whenever no payload byte is scheduled.
REQ-003 clk  in  1  bit-rate clock (one serial bit per rising edge); the block SHALL have exactly this one clock.
REQ-004 reset  in  1  asynchronous, active-low reset; all flops SHALL clear immediately when reset is 0.
REQ-005 data_in  in  32  payload word, byte [31:24] sent first.
REQ-006 valid_in  in  1  data_in is valid this cycle.
REQ-007 ready_out  out  1  block can accept a word this cycle; transfer occurs on a rising edge with valid_in=1 and ready_out=1.
REQ-008 serial_out  out  1  serial lane bit, MSB of each byte first.
REQ-009 sending_out  out  1  high for all 8 bit-cycles of every payload byte, low for idle bytes.

Function
REQ-010 The block SHALL contain a 3-bit bit counter that increments every cycle and wraps 7->0; the cycle with count 7 is the byte boundary.
REQ-011 serial_out SHALL be bit 7 of an 8-bit shift register; on non-boundary edges the register shifts left by one; on boundary edges it loads the next byte.
REQ-012 The block SHALL hold one word in a hold buffer; ready_out SHALL equal NOT hold_full, registered, with no combinational path from valid_in.
REQ-013 A handshake SHALL set hold_full on the next edge; ready_out SHALL be 0 in the following cycle.
REQ-014 The FSM SHALL have states SYNC, IDLE and DATA, with the transitions in REQ-015 to REQ-018.
REQ-015 SYNC: send IDLE_K and count bytes; after SYNC_BC complete idle bytes, move to IDLE.
REQ-016 IDLE: at a boundary with hold_full=1, move the hold word into the word register, load byte [31:24], clear hold_full and enter DATA; otherwise load IDLE_K.
REQ-017 DATA: at the boundaries after bytes 0, 1 and 2, load bytes [23:16], [15:8] and [7:0] in order using a 2-bit byte counter.
REQ-018 DATA, after byte 3: if hold_full=1, load the next word with no idle gap and stay in DATA; otherwise load IDLE_K and return to IDLE.
REQ-019 Sustained throughput SHALL be one word per 32 clk cycles while the hold buffer stays full.
REQ-020 Latency: a word accepted while IDLE with bit count k SHALL start on serial_out (its first bit) at the edge after the next boundary, i.e. within 1 to 8 cycles.
REQ-021 Simultaneous handshake and hold-drain in one cycle is impossible because ready_out=0 while full; ready_out SHALL rise the cycle after the drain.
REQ-022 valid_in SHALL be ignored while ready_out=0; the hold contents SHALL NOT change.
REQ-023 Payload bytes equal to IDLE_K SHALL be sent unchanged; lane-level disambiguation is outside this block.
REQ-024 sending_out SHALL be loaded at each boundary together with the shift register: 1 for a payload byte, 0 for an idle byte.

Reset
REQ-025 While reset=0: serial_out=1 (IDLE_K bit 7), shift register=IDLE_K, bit count=0, byte count=0, state=SYNC, sync count=0, hold_full=0, ready_out=0, sending_out=0.
REQ-026 ready_out SHALL rise on the first edge after reset deasserts; words accepted during SYNC SHALL wait in the hold buffer.
REQ-027 Reset asserted mid-word SHALL discard the word in flight and the hold word; after release, the full SYNC_BC idle sequence SHALL repeat.

Structure
REQ-028 A shared package SHALL hold the K28.5 constant 8'hBC, the FSM state encoding, and the bit-counter and byte-counter widths, for reuse by the receive lane.
REQ-029 The one-entry valid/ready hold buffer SHALL be a sub-module named lane_tx_hold; the remaining logic stays in lane_tx_serializer.

Verification
REQ-030 Reset release, no valid -> serial_out repeats 10111100 forever, sending_out=0, ready_out=1 from cycle 1.
REQ-031 Word 32'hDEADBEEF with valid_in=1 at cycle 0 after reset -> 32 idle bits (SYNC_BC=4) precede DE,AD,BE,EF MSB-first; sending_out high for exactly 32 cycles; BC resumes.
REQ-032 Back-to-back words 32'h01234567 and 32'h89ABCDEF, valid held high -> 64 contiguous payload bits with no BC gap, ready_out pulses low/high once per word.
REQ-033 valid_in held with ready_out=0 and data_in changing -> sent word equals the value present at the accepting edge only.
REQ-034 Reset asserted at bit 13 of 32'hCAFEF00D, released 5 cycles later -> serial_out=1 immediately, 4 BC bytes sent, CAFEF00D never completes, hold empty.
REQ-035 Payload 32'hBCBCBCBC -> four BC bytes sent with sending_out=1 throughout.

Source files
------------

// File: rtl/lane_tx_serializer_pkg.sv
// Shared lane constants and types: comma byte, FSM encoding and counter widths,
// used by the transmit serializer and reusable by the receive lane.
package lane_tx_serializer_pkg;

  localparam logic [7:0] K28_5      = 8'hBC;
  localparam int         BIT_CNT_W  = 3;
  localparam int         BYTE_CNT_W = 2;
  localparam int         WORD_W     = 32;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2
  } lane_state_e;

  // Byte 0 is the most significant byte, the first one on the lane.
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0]     w,
                                           input logic [BYTE_CNT_W-1:0] idx);
    case (idx)
      2'd0:    word_byte = w[31:24];
      2'd1:    word_byte = w[23:16];
      2'd2:    word_byte = w[15:8];
      default: word_byte = w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/lane_tx_serializer_if.sv
// Word handshake between a payload producer (master) and the lane serializer (slave).
interface lane_tx_serializer_if;
  import lane_tx_serializer_pkg::*;

  logic [WORD_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);

endinterface

// File: rtl/lane_tx_hold.sv
// One-entry valid/ready hold buffer; ready is a flop so valid_i never reaches ready_o
// combinationally.
module lane_tx_hold
  import lane_tx_serializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              drain_i,
  output logic              ready_o,
  output logic              full_o,
  output logic [WORD_W-1:0] word_o
);

  logic              full_q, full_d;
  logic              ready_q;
  logic [WORD_W-1:0] word_q, word_d;
  logic              take;

  assign take = valid_i & ready_q;

  // A take and a drain never coincide: ready_q is low whenever the buffer is full.
  always_comb begin
    full_d = full_q;
    word_d = word_q;
    if (take) begin
      full_d = 1'b1;
      word_d = data_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      word_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= ~full_d;
      word_q  <= word_d;
    end
  end

  assign ready_o = ready_q;
  assign full_o  = full_q;
  assign word_o  = word_q;

endmodule

// File: rtl/lane_tx_serializer.sv
// Byte-framed serial lane transmitter: SYNC_BC comma bytes after reset, then payload
// words MSB-first with commas filling every slot that has no payload byte.
module lane_tx_serializer
  import lane_tx_serializer_pkg::*;
#(
  parameter int unsigned SYNC_BC = 4,
  parameter logic [7:0]  IDLE_K  = K28_5
) (
  input  logic                clk,
  input  logic                reset,
  lane_tx_serializer_if.slave bus,
  output logic                serial_out,
  output logic                sending_out
);

  localparam int                SYNC_W    = (SYNC_BC > 1) ? $clog2(SYNC_BC) : 1;
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_BC - 1);

  lane_state_e             state_q, state_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BYTE_CNT_W-1:0]   next_byte;
  logic [SYNC_W-1:0]       sync_cnt_q, sync_cnt_d;
  logic [7:0]              sh_q, sh_d;
  logic                    sending_q, sending_d;
  logic [WORD_W-1:0]       word_q, word_d;

  logic                    hold_full;
  logic [WORD_W-1:0]       hold_word;
  logic                    drain;
  logic                    boundary;
  logic                    sync_done;
  logic                    last_byte;
  logic                    load_hold;

  lane_tx_hold u_hold (
    .clk     (clk),
    .rst_n   (reset),
    .valid_i (bus.valid_in),
    .data_i  (bus.data_in),
    .drain_i (drain),
    .ready_o (bus.ready_out),
    .full_o  (hold_full),
    .word_o  (hold_word)
  );

  assign boundary  = (bit_cnt_q == '1);
  assign sync_done = (state_q == ST_SYNC) && (sync_cnt_q == SYNC_LAST);
  assign last_byte = (byte_cnt_q == '1);
  assign next_byte = byte_cnt_q + 1'b1;

  // The boundary that completes the last sync byte already behaves like an idle
  // boundary, so a word waiting in the hold buffer follows the sync bytes with no gap.
  assign load_hold = boundary && hold_full &&
                     (sync_done || (state_q == ST_IDLE) ||
                      ((state_q == ST_DATA) && last_byte));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (boundary) begin
      case (state_q)
        ST_SYNC: if (sync_done) state_d = hold_full ? ST_DATA : ST_IDLE;
        ST_IDLE: if (hold_full) state_d = ST_DATA;
        ST_DATA: if (last_byte && !hold_full) state_d = ST_IDLE;
        default: state_d = ST_SYNC;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q + 1'b1;
    sh_d       = {sh_q[6:0], 1'b0};
    sending_d  = sending_q;
    byte_cnt_d = byte_cnt_q;
    sync_cnt_d = sync_cnt_q;
    word_d     = word_q;
    drain      = 1'b0;
    if (boundary) begin
      sh_d      = IDLE_K;
      sending_d = 1'b0;
      if ((state_q == ST_SYNC) && !sync_done) begin
        sync_cnt_d = sync_cnt_q + 1'b1;
      end
      if (load_hold) begin
        drain      = 1'b1;
        word_d     = hold_word;
        sh_d       = word_byte(hold_word, '0);
        sending_d  = 1'b1;
        byte_cnt_d = '0;
      end else if ((state_q == ST_DATA) && !last_byte) begin
        sh_d       = word_byte(word_q, next_byte);
        sending_d  = 1'b1;
        byte_cnt_d = next_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sync_cnt_q <= '0;
      sh_q       <= IDLE_K;
      sending_q  <= 1'b0;
      word_q     <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      sh_q       <= sh_d;
      sending_q  <= sending_d;
      word_q     <= word_d;
    end
  end

  assign serial_out  = sh_q[7];
  assign sending_out = sending_q;

endmodule

// File: tb/tb_lane_tx_serializer.sv
// Bench for lane_tx_serializer: a byte-slot reference model checks every cycle, and
// table vectors plus hand sequences check framing, back-to-back words and reset.
module tb_lane_tx_serializer;

  localparam int         SYNC_BC = 4;
  localparam logic [7:0] IDLE    = 8'hBC;
  localparam int         HMAX    = 4096;

  logic clk;
  logic reset;
  logic serial_out;
  logic sending_out;

  lane_tx_serializer_if bus ();

  lane_tx_serializer #(.SYNC_BC(SYNC_BC), .IDLE_K(IDLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .serial_out  (serial_out),
    .sending_out (sending_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: lane is a sequence of 8-cycle byte slots fed from a byte queue.
  int          m_t;
  logic [7:0]  m_byte;
  bit          m_payload;
  logic [31:0] m_hold[$];
  logic [7:0]  m_lane[$];
  logic [31:0] m_acc[$];

  logic hist_ser[HMAX];
  logic hist_snd[HMAX];
  logic hist_rdy[HMAX];

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_payload;
    logic [7:0]  exp_tail;
    int          exp_lead;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, m_t);
    end
  endtask

  // Called at a falling edge: check cycle m_t, drive its inputs, advance the model.
  task automatic step(input logic v, input logic [31:0] d, output bit took);
    logic        exp_rdy;
    logic [31:0] w;
    exp_rdy = (m_t != 0) && (m_hold.size() == 0);
    chk("serial_out", 64'(serial_out), 64'(m_byte[7 - (m_t % 8)]));
    chk("sending_out", 64'(sending_out), 64'(m_payload));
    chk("ready_out", 64'(bus.ready_out), 64'(exp_rdy));
    if (m_t < HMAX) begin
      hist_ser[m_t] = serial_out;
      hist_snd[m_t] = sending_out;
      hist_rdy[m_t] = bus.ready_out;
    end
    bus.valid_in = v;
    bus.data_in  = d;
    took = v && exp_rdy;
    if (m_t % 8 == 7) begin
      if ((m_t + 1) / 8 < SYNC_BC) begin
        m_byte = IDLE; m_payload = 1'b0;
      end else if (m_lane.size() > 0) begin
        m_byte = m_lane.pop_front(); m_payload = 1'b1;
      end else if (m_hold.size() > 0) begin
        w = m_hold.pop_front();
        m_lane.push_back(w[23:16]);
        m_lane.push_back(w[15:8]);
        m_lane.push_back(w[7:0]);
        m_byte = w[31:24]; m_payload = 1'b1;
      end else begin
        m_byte = IDLE; m_payload = 1'b0;
      end
    end
    if (took) begin
      m_hold.push_back(d);
      m_acc.push_back(d);
    end
    m_t++;
    @(negedge clk);
  endtask

  // Entered and left at a falling edge; reset asserts mid-cycle to exercise the async path.
  task automatic apply_reset(input int n);
    #2;
    reset = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    chk("rst_serial", 64'(serial_out), 64'd1);
    chk("rst_sending", 64'(sending_out), 64'd0);
    chk("rst_ready", 64'(bus.ready_out), 64'd0);
    repeat (n) @(negedge clk);
    reset = 1'b1;
    m_t = 0; m_byte = IDLE; m_payload = 1'b0;
    m_hold.delete(); m_lane.delete(); m_acc.delete();
    for (int i = 0; i < HMAX; i++) begin
      hist_ser[i] = 1'bx; hist_snd[i] = 1'bx; hist_rdy[i] = 1'bx;
    end
  endtask

  function automatic int count_snd();
    int n = 0;
    for (int i = 0; i < m_t && i < HMAX; i++) if (hist_snd[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_snd();
    for (int i = 0; i < m_t && i < HMAX; i++) if (hist_snd[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic logic [63:0] bits_at(input int start, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++)
      r = {r[62:0], (start + i >= 0 && start + i < HMAX) ? hist_ser[start + i] : 1'bx};
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    bit   took;
    int   acc;
    int   f;
    int   falls;
    int   rises;
    int   run;
    int   best;

    reset = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    m_t = 0; m_byte = IDLE; m_payload = 1'b0;
    @(negedge clk);

    vecs[0] = '{32'hDEADBEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 8'hBC, 32};
    vecs[1] = '{32'hBCBCBCBC, {8'hBC, 8'hBC, 8'hBC, 8'hBC}, 8'hBC, 32};
    vecs[2] = '{32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}, 8'hBC, 32};
    vecs[3] = '{32'hFFFFFFFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hBC, 32};
    vecs[4] = '{32'hA5015AC3, {8'hA5, 8'h01, 8'h5A, 8'hC3}, 8'hBC, 32};

    // Idle lane after reset.
    apply_reset(2);
    for (int c = 0; c < 64; c++) step(1'b0, 32'h0, took);
    chk("idle_bits", bits_at(0, 64), 64'hBCBCBCBCBCBCBCBC);
    chk("idle_snd", 64'(count_snd()), 64'd0);
    chk("idle_rdy0", 64'(hist_rdy[0]), 64'd0);
    chk("idle_rdy1", 64'(hist_rdy[1]), 64'd1);

    // Single words offered from cycle 0 after reset.
    for (int i = 0; i < 5; i++) begin
      apply_reset(2);
      acc = 0;
      for (int c = 0; c < 90; c++) begin
        step(acc == 0, vecs[i].word, took);
        if (took) acc = 1;
      end
      chk("vec_accepted", 64'(acc), 64'd1);
      f = first_snd();
      chk("vec_lead", 64'(f), 64'(vecs[i].exp_lead));
      chk("vec_sync_bits", bits_at(0, 32), 64'hBCBCBCBC);
      chk("vec_payload", bits_at(f, 32), 64'(vecs[i].exp_payload));
      chk("vec_tail", bits_at(f + 32, 8), 64'(vecs[i].exp_tail));
      chk("vec_snd_len", 64'(count_snd()), 64'd32);
    end

    // Back-to-back words with valid held high.
    apply_reset(3);
    acc = 0;
    for (int c = 0; c < 130; c++) begin
      step(acc < 2, (acc == 0) ? 32'h01234567 : 32'h89ABCDEF, took);
      if (took) acc++;
    end
    chk("b2b_lead", 64'(first_snd()), 64'd32);
    chk("b2b_bits", bits_at(32, 64), 64'h0123456789ABCDEF);
    best = 0; run = 0;
    for (int i = 0; i < m_t; i++) begin
      run = (hist_snd[i] === 1'b1) ? run + 1 : 0;
      if (run > best) best = run;
    end
    chk("b2b_run", 64'(best), 64'd64);
    falls = 0; rises = 0;
    for (int i = 2; i < m_t; i++) begin
      if (hist_rdy[i - 1] === 1'b1 && hist_rdy[i] === 1'b0) falls++;
      if (hist_rdy[i - 1] === 1'b0 && hist_rdy[i] === 1'b1) rises++;
    end
    chk("b2b_rdy_falls", 64'(falls), 64'd2);
    chk("b2b_rdy_rises", 64'(rises), 64'd2);

    // Valid held while not ready, data changing every cycle.
    apply_reset(2);
    for (int c = 0; c < 100; c++) step(1'b1, $urandom, took);
    if (m_acc.size() >= 2) begin
      chk("chg_word0", bits_at(32, 32), 64'(m_acc[0]));
      chk("chg_word1", bits_at(64, 32), 64'(m_acc[1]));
    end else begin
      chk("chg_accepts", 64'(m_acc.size()), 64'd2);
    end

    // Reset at bit 13 of a word while a second word waits in the hold buffer.
    apply_reset(2);
    acc = 0;
    for (int c = 0; c < 200; c++) begin
      step(acc < 2, (acc == 0) ? 32'hCAFEF00D : 32'h12345678, took);
      if (took) acc++;
      if (count_snd() == 13) break;
    end
    chk("mid_reached", 64'(count_snd()), 64'd13);
    chk("mid_hold_full", 64'(bus.ready_out), 64'd0);
    apply_reset(5);
    for (int c = 0; c < 80; c++) step(1'b0, 32'h0, took);
    chk("mid_post_snd", 64'(count_snd()), 64'd0);
    chk("mid_post_bits", bits_at(0, 64), 64'hBCBCBCBCBCBCBCBC);
    chk("mid_post_rdy", 64'(hist_rdy[1]), 64'd1);

    // Random traffic against the model.
    apply_reset(2);
    for (int c = 0; c < 2000; c++) step($urandom_range(0, 3) != 0, $urandom, took);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
